// File: rtl/score_record_bank_pkg.sv
// Shared constants and helpers for the learning-mode score record bank.
//   SONG_AVG_SLOT  song index reserved for the average display slot (never stored)
//   NUM_USERS      number of users held in the bank
//   NUM_SONGS      stored songs per user
//   AVG_*          average-engine FSM state encodings
//   rec_idx()      flat record index {user, song}
package score_record_bank_pkg;

  localparam logic [1:0]  SONG_AVG_SLOT = 2'b11;
  localparam int unsigned NUM_USERS     = 4;
  localparam int unsigned NUM_SONGS     = 3;
  // Flat array is indexed {user, song}, so song 3 of each user is a hole that stays zero.
  localparam int unsigned NUM_SLOTS     = NUM_USERS * 4;

  localparam logic [1:0] AVG_IDLE = 2'd0;
  localparam logic [1:0] AVG_LOAD = 2'd1;
  localparam logic [1:0] AVG_DIV  = 2'd2;
  localparam logic [1:0] AVG_DONE = 2'd3;

  function automatic logic [3:0] rec_idx(input logic [1:0] u, input logic [1:0] s);
    return {u, s};
  endfunction

endpackage

// File: rtl/score_record_bank_div3_seq.sv
// Serial restoring divide-by-3, one quotient bit per cycle, MSB first.
//   clk, rst     clock, synchronous active-high reset
//   i_start      load i_dividend and begin dividing (ignored semantics left to the caller)
//   i_dividend   Width-bit dividend
//   o_busy       iteration in progress (Width cycles after i_start)
//   o_done       high during the final iteration; o_quotient is complete the cycle after
//   o_quotient   floor(dividend / 3), valid once o_busy has dropped
module div3_seq #(
  parameter int unsigned Width = 43
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [Width-1:0] i_dividend,
  output logic             o_busy,
  output logic             o_done,
  output logic [Width-1:0] o_quotient
);

  localparam int unsigned CntW = (Width > 1) ? $clog2(Width) : 1;

  // r_work starts as the dividend; each step shifts out a dividend bit at the top and a
  // quotient bit in at the bottom, so after Width steps it holds the quotient.
  logic [Width-1:0] r_work;
  logic [1:0]       r_rem;
  logic [CntW-1:0]  r_cnt;
  logic             r_busy;

  logic [2:0] w_trial;
  logic       w_ge;
  logic [1:0] w_rem_d;

  // Remainder is always < 3, so the trial value is at most 5 and trial-3 fits in 2 bits.
  always_comb begin
    w_trial = {r_rem, r_work[Width-1]};
    w_ge    = (w_trial >= 3'd3);
    w_rem_d = w_ge ? 2'(w_trial - 3'd3) : w_trial[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_work <= i_dividend;
      r_rem  <= '0;
      r_cnt  <= CntW'(Width - 1);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_work <= {r_work[Width-2:0], w_ge};
      r_rem  <= w_rem_d;
      r_cnt  <= r_cnt - 1'b1;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_busy && (r_cnt == '0);
  assign o_quotient = r_work;

endmodule

// File: rtl/score_record_bank.sv
// Learning-mode score history: 4 users x 3 songs of SCORE_W-bit records.
//   clk, rst              clock, synchronous active-high reset
//   finished              "song complete" level; its rising edge captures score
//   user, song_num, score capture address and data (song 3 edges are ignored)
//   rd_user, rd_song      read address; rd_score is the registered record (song 3 reads 0)
//   avg_start, avg_user   start a 3-song average for avg_user (ignored while busy)
//   avg_busy              average in progress (LOAD, DIV, DONE)
//   avg_valid             one-cycle pulse; avg_score carries the new average this cycle
//   avg_score             floor((r0+r1+r2)/3) of the last completed request, held
module score_record_bank
  import score_record_bank_pkg::*;
#(
  parameter int unsigned SCORE_W = 41
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               finished,
  input  logic [1:0]         user,
  input  logic [1:0]         song_num,
  input  logic [SCORE_W-1:0] score,
  input  logic [1:0]         rd_user,
  input  logic [1:0]         rd_song,
  output logic [SCORE_W-1:0] rd_score,
  input  logic               avg_start,
  input  logic [1:0]         avg_user,
  output logic               avg_busy,
  output logic               avg_valid,
  output logic [SCORE_W-1:0] avg_score
);

  localparam int unsigned SumW = SCORE_W + 2;

  // ---------------------------------------------------------------------------
  // Record array, capture and read port
  // ---------------------------------------------------------------------------
  logic [SCORE_W-1:0] r_rec [NUM_SLOTS];
  logic               r_fin;
  logic [SCORE_W-1:0] r_rd_score;
  logic               w_capture;

  assign w_capture = finished && !r_fin && (song_num != SONG_AVG_SLOT);

  // The read samples the pre-write array, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        r_rec[i] <= '0;
      end
      r_fin      <= 1'b0;
      r_rd_score <= '0;
    end else begin
      r_fin <= finished;
      if (w_capture) begin
        r_rec[rec_idx(user, song_num)] <= score;
      end
      if (rd_song == SONG_AVG_SLOT) begin
        r_rd_score <= '0;
      end else begin
        r_rd_score <= r_rec[rec_idx(rd_user, rd_song)];
      end
    end
  end

  assign rd_score = r_rd_score;

  // ---------------------------------------------------------------------------
  // Average engine
  // ---------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [1:0]         w_state_d;
  logic [1:0]         r_avg_user;
  logic [SCORE_W-1:0] r_avg_score;
  logic [SumW-1:0]    w_sum;
  logic               w_div_start;
  logic               w_div_done;
  logic               w_unused_div_busy;
  logic [SumW-1:0]    w_quot;
  logic [1:0]         w_unused_quot_msbs;

  // Summed in LOAD only; the divider latches it, so later captures cannot disturb the request.
  always_comb begin
    w_sum = '0;
    for (int s = 0; s < int'(NUM_SONGS); s++) begin
      w_sum = w_sum + {2'b00, r_rec[rec_idx(r_avg_user, 2'(s))]};
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_div_start = 1'b0;
    unique case (r_state)
      AVG_IDLE: if (avg_start) w_state_d = AVG_LOAD;
      AVG_LOAD: begin
        w_div_start = 1'b1;
        w_state_d   = AVG_DIV;
      end
      AVG_DIV:  if (w_div_done) w_state_d = AVG_DONE;
      AVG_DONE: w_state_d = AVG_IDLE;
      default:  w_state_d = AVG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= AVG_IDLE;
      r_avg_user  <= '0;
      r_avg_score <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == AVG_IDLE && avg_start) begin
        r_avg_user <= avg_user;
      end
      if (r_state == AVG_DONE) begin
        r_avg_score <= w_quot[SCORE_W-1:0];
      end
    end
  end

  div3_seq #(
    .Width (SumW)
  ) u_div3 (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_sum),
    .o_busy     (w_unused_div_busy),
    .o_done     (w_div_done),
    .o_quotient (w_quot)
  );

  // sum/3 never exceeds one record, so the top two quotient bits are always zero.
  assign w_unused_quot_msbs = w_quot[SumW-1:SCORE_W];

  assign avg_busy  = (r_state != AVG_IDLE);
  assign avg_valid = (r_state == AVG_DONE);
  // Forward the fresh quotient during DONE so avg_score and avg_valid line up.
  assign avg_score = avg_valid ? w_quot[SCORE_W-1:0] : r_avg_score;

endmodule
